mem_arb: RTL and testbench

Single-port memory arbiter and access sequencer for the SISC processor. It shares one unified instruction/data memory between the instruction-fetch path and the load/store data path. It uses a request/acknowledge handshake per requester and a round-robin tie-break. It counts out a fixed memory latency before returning read data. It sits between the fetch logic (PC/IR side), the load/store datapath, and the memory array.

---
 rtl/mem_arb.sv | 143 ++++++++++++++
 tb/tb_mem_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter for fetch and load/store paths
// Round-robin grant, fixed-latency access sequencing, registered read data and acks.
module mem_arb #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic       OWN_F    = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [3:0]      lat_cnt_q, lat_cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            f_ack_q, f_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            busy_q, busy_d;
  logic            grant_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    // On a tie the requester that was not served last wins.
    grant_data  = d_req && (!f_req || (last_q == OWN_F));

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          owner_d     = grant_data ? OWN_D : OWN_F;
          last_d      = grant_data ? OWN_D : OWN_F;
          mem_addr_d  = grant_data ? d_addr : f_addr;
          mem_wdata_d = grant_data ? d_wdata : '0;
          mem_we_d    = grant_data && d_we;
          mem_en_d    = 1'b1;
          lat_cnt_d   = LAT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == 4'd0) begin
          if (owner_q == OWN_F) begin
            f_rdata_d = mem_rdata;
            f_ack_d   = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_ack_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      last_q      <= OWN_F;
      lat_cnt_q   <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed vector bench for mem_arb
// Table of per-cycle vectors for MEM_LAT=2 plus hand sequences for reset, round-robin and MEM_LAT=1.
module tb_mem_arb;

  localparam logic [31:0] FR = 32'h12345678;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        f_ack, d_ack, mem_en, mem_we, busy;
  logic [31:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem [0:255];

  logic        f_req1 = 1'b0;
  logic [15:0] f_addr1 = '0;
  logic        f_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic [31:0] f_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb #(.MEM_LAT(2), .AW(16), .DW(32)) u_dut (
    .clk(clk), .rst_f(rst_f),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.MEM_LAT(1), .AW(16), .DW(32)) u_dut1 (
    .clk(clk), .rst_f(rst_f),
    .f_req(f_req1), .f_addr(f_addr1), .f_ack(f_ack1), .f_rdata(f_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Two fixed ROM words, everything else comes from the writable array.
  assign mem_rdata  = (mem_addr == 16'h0004) ? FR :
                      (mem_addr == 16'h0020) ? CF : mem[mem_addr[7:0]];
  assign mem_rdata1 = {16'hA5A5, mem_addr1};

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_fack;
    logic        e_dack;
    logic        e_en;
    logic        e_we;
    logic        e_busy;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_fr;
    logic [31:0] e_dr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic fq, logic [15:0] fa, logic dq, logic dw,
                             logic [15:0] da, logic [31:0] dd, logic efa, logic eda,
                             logic een, logic ewe, logic ebs, logic [15:0] ea,
                             logic [31:0] ewd, logic [31:0] efr, logic [31:0] edr);
    vec_t r;
    r.f_req = fq;  r.f_addr = fa;  r.d_req = dq;  r.d_we = dw;
    r.d_addr = da; r.d_wdata = dd; r.e_fack = efa; r.e_dack = eda;
    r.e_en = een;  r.e_we = ewe;   r.e_busy = ebs; r.e_addr = ea;
    r.e_wdata = ewd; r.e_fr = efr; r.e_dr = edr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " f_ack"}, f_ack, 0);
    chk({tag, " d_ack"}, d_ack, 0);
    chk({tag, " mem_en"}, mem_en, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " f_rdata"}, f_rdata, 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    // Fetch, store, load with a fetch raised mid-access that must wait.
    vecs.push_back(v(1, 16'h04, 0, 0, 16'h00, 0,  0, 0, 0, 0, 0, 16'h00, 0, 0,  0));
    vecs.push_back(v(1, 16'h04, 0, 0, 16'h00, 0,  0, 0, 1, 0, 1, 16'h04, 0, 0,  0));
    vecs.push_back(v(1, 16'h04, 0, 0, 16'h00, 0,  0, 0, 1, 0, 1, 16'h04, 0, 0,  0));
    vecs.push_back(v(1, 16'h04, 0, 0, 16'h00, 0,  1, 0, 0, 0, 1, 16'h00, 0, FR, 0));
    vecs.push_back(v(0, 16'h04, 1, 1, 16'h10, DB, 0, 0, 0, 0, 0, 16'h00, 0, FR, 0));
    vecs.push_back(v(0, 16'h00, 1, 1, 16'h10, DB, 0, 0, 1, 1, 1, 16'h10, DB, FR, 0));
    vecs.push_back(v(0, 16'h00, 1, 1, 16'h10, DB, 0, 0, 1, 1, 1, 16'h10, DB, FR, 0));
    vecs.push_back(v(0, 16'h00, 1, 1, 16'h10, DB, 0, 1, 0, 0, 1, 16'h00, 0, FR, 0));
    vecs.push_back(v(0, 16'h00, 1, 0, 16'h10, 0,  0, 0, 0, 0, 0, 16'h00, 0, FR, 0));
    vecs.push_back(v(1, 16'h20, 1, 0, 16'h10, 0,  0, 0, 1, 0, 1, 16'h10, 0, FR, 0));
    vecs.push_back(v(1, 16'h20, 1, 0, 16'h10, 0,  0, 0, 1, 0, 1, 16'h10, 0, FR, 0));
    vecs.push_back(v(1, 16'h20, 1, 0, 16'h10, 0,  0, 1, 0, 0, 1, 16'h00, 0, FR, DB));
    vecs.push_back(v(1, 16'h20, 0, 0, 16'h00, 0,  0, 0, 0, 0, 0, 16'h00, 0, FR, DB));
    vecs.push_back(v(1, 16'h20, 0, 0, 16'h00, 0,  0, 0, 1, 0, 1, 16'h20, 0, FR, DB));
    vecs.push_back(v(1, 16'h20, 0, 0, 16'h00, 0,  0, 0, 1, 0, 1, 16'h20, 0, FR, DB));
    vecs.push_back(v(1, 16'h20, 0, 0, 16'h00, 0,  1, 0, 0, 0, 1, 16'h00, 0, CF, DB));
    vecs.push_back(v(0, 16'h00, 0, 0, 16'h00, 0,  0, 0, 0, 0, 0, 16'h00, 0, CF, DB));

    // Reset held two cycles with both requests high.
    cyc();
    rst_f = 1'b1; f_req = 1'b1; d_req = 1'b1;
    cyc();
    chk_reset_outputs("reset1");
    cyc();
    chk_reset_outputs("reset2");
    rst_f = 1'b0; f_req = 1'b0; d_req = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      cyc();
      chk($sformatf("v%0d f_ack", k), f_ack, vecs[k].e_fack);
      chk($sformatf("v%0d d_ack", k), d_ack, vecs[k].e_dack);
      chk($sformatf("v%0d mem_en", k), mem_en, vecs[k].e_en);
      chk($sformatf("v%0d mem_we", k), mem_we, vecs[k].e_we);
      chk($sformatf("v%0d busy", k), busy, vecs[k].e_busy);
      if (vecs[k].e_en) chk($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].e_addr);
      if (vecs[k].e_we) chk($sformatf("v%0d mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      chk($sformatf("v%0d f_rdata", k), f_rdata, vecs[k].e_fr);
      chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].e_dr);
      f_req = vecs[k].f_req;   f_addr = vecs[k].f_addr;
      d_req = vecs[k].d_req;   d_we = vecs[k].d_we;
      d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
    end

    // Round-robin from reset: data first, then alternating.
    cyc();
    rst_f = 1'b1; f_req = 1'b0; d_req = 1'b0;
    cyc();
    rst_f = 1'b0; f_req = 1'b1; f_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      chk($sformatf("rr c%0d f_ack", c), f_ack, (c == 7 || c == 15));
      chk($sformatf("rr c%0d d_ack", c), d_ack, (c == 3 || c == 11));
      if (c == 3) chk("rr d_rdata", d_rdata, DB);
      if (c == 7) chk("rr f_rdata", f_rdata, FR);
    end
    f_req = 1'b0; d_req = 1'b0;

    // Reset during ACCESS abandons the fetch.
    cyc();
    rst_f = 1'b1;
    cyc();
    rst_f = 1'b0; f_req = 1'b1; f_addr = 16'h0008;
    cyc();
    chk("rst_mid c1 mem_en", mem_en, 1);
    chk("rst_mid c1 busy", busy, 1);
    rst_f = 1'b1;
    cyc();
    chk("rst_mid c2 mem_en", mem_en, 0);
    chk("rst_mid c2 busy", busy, 0);
    chk("rst_mid c2 f_ack", f_ack, 0);
    rst_f = 1'b0; f_req = 1'b0;
    for (int c = 3; c < 9; c++) begin
      cyc();
      chk($sformatf("rst_mid c%0d f_ack", c), f_ack, 0);
    end

    // MEM_LAT=1 back-to-back fetches, period 3.
    f_req1 = 1'b1; f_addr1 = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk($sformatf("lat1 c%0d f_ack", c), f_ack1, (c == 2 || c == 5 || c == 8));
      chk($sformatf("lat1 c%0d mem_en", c), mem_en1, (c == 1 || c == 4 || c == 7));
      if (c == 2) chk("lat1 f_rdata0", f_rdata1, 32'hA5A50000);
      if (c == 5) chk("lat1 f_rdata1", f_rdata1, 32'hA5A50001);
      if (c == 8) chk("lat1 f_rdata2", f_rdata1, 32'hA5A50002);
      if (c == 3) f_addr1 = 16'h0001;
      if (c == 6) f_addr1 = 16'h0002;
      if (c == 9) f_req1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Both acks together is never legal.
  always @(negedge clk) begin
    if (!rst_f && f_ack && d_ack) begin
      errors++;
      $display("FAIL dual_ack actual=1 expected=0");
    end
  end

endmodule
